// File: rtl/dm_arbiter.sv
// Two-requester arbiter for the single-port data memory: registers the winning
// command, strobes the DM for one cycle and returns read data after RD_LAT cycles.
// Optional macro DM_ARB_FIXED_PRIO_EN: requester 0 always wins a tie (default round-robin).
module dm_arbiter #(
  parameter int unsigned AW     = 64,
  parameter int unsigned DW     = 64,
  parameter int unsigned RD_LAT = 1   // legal range 1..7
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,

  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,

  output logic [DW-1:0] rdata,

  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StRwait  = 2'd2;

  localparam logic [2:0] LatLoad = 3'(RD_LAT - 1);

  logic [1:0]    state_q, state_d;
  logic [2:0]    lat_cnt_q, lat_cnt_d;
  logic          rr_last_q, rr_last_d;
  logic          winner_q, winner_d;
  logic          cmd_we_q, cmd_we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          any_req;
  logic          pick;
  logic          in_access;
  logic          data_ok;

  // pick: 0 selects requester 0, 1 selects requester 1
  always_comb begin
    any_req = req0 | req1;
`ifdef DM_ARB_FIXED_PRIO_EN
    pick = ~req0;
`else
    if (req0 && req1) begin
      pick = ~rr_last_q;
    end else begin
      pick = ~req0;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    rr_last_d = rr_last_q;
    winner_d  = winner_q;
    cmd_we_d  = cmd_we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          winner_d = pick;
          cmd_we_d = pick ? we1    : we0;
          addr_d   = pick ? addr1  : addr0;
          wdata_d  = pick ? wdata1 : wdata0;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        rr_last_d = winner_q;
        if (cmd_we_q) begin
          state_d = StIdle;
        end else begin
          lat_cnt_d = LatLoad;
          state_d   = StRwait;
        end
      end
      StRwait: begin
        if (lat_cnt_q != 3'd0) begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      lat_cnt_q <= 3'd0;
      rr_last_q <= 1'b1;  // requester 0 wins the first tie
      winner_q  <= 1'b0;
      cmd_we_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      rr_last_q <= rr_last_d;
      winner_q  <= winner_d;
      cmd_we_q  <= cmd_we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Strobes decode straight from state so an asynchronous reset clears them at once.
  always_comb begin
    in_access = (state_q == StAccess);
    data_ok   = (state_q == StRwait) && (lat_cnt_q == 3'd0);
    mem_write = in_access &  cmd_we_q;
    mem_read  = in_access & ~cmd_we_q;
    gnt0      = in_access & ~winner_q;
    gnt1      = in_access &  winner_q;
    rvalid0   = data_ok   & ~winner_q;
    rvalid1   = data_ok   &  winner_q;
    rdata     = data_ok ? mem_rdata : '0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
  end

`ifndef SYNTHESIS
  a_strobe_excl: assert property (@(posedge clk) disable iff (reset) !(mem_read && mem_write));
  a_gnt_excl:    assert property (@(posedge clk) disable iff (reset) !(gnt0 && gnt1));
  a_rvalid_excl: assert property (@(posedge clk) disable iff (reset) !(rvalid0 && rvalid1));
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized bench for dm_arbiter: a transaction-level timing model predicts
// every grant, strobe and read return; asynchronous resets are injected mid-read.
module tb_dm_arbiter;

  localparam int unsigned AW        = 64;
  localparam int unsigned DW        = 64;
  localparam int unsigned RdLat     = 3;
  localparam int          NumCycles = 3000;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  dm_arbiter #(
    .AW    (AW),
    .DW    (DW),
    .RD_LAT(RdLat)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .we0      (we0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .gnt0     (gnt0),
    .rvalid0  (rvalid0),
    .req1     (req1),
    .we1      (we1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .gnt1     (gnt1),
    .rvalid1  (rvalid1),
    .rdata    (rdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc      = -1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_strobes"}, 64'({gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write}), 64'd0);
    check_eq({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check_eq({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check_eq({tag, "_rdata"}, 64'(rdata), 64'd0);
  endtask

  // Requester-side state: a held request and its command fields.
  logic          busy [2];
  logic          r_we [2];
  logic [AW-1:0] r_addr [2];
  logic [DW-1:0] r_wdata [2];

  // Reference model: the arbiter is free from cycle free_at on; one transaction in flight.
  int            free_at;
  int            rr_last;
  int            t_gnt, t_rv, t_id;
  logic          t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata;
  int            n_resets;
  bit            force_both;
  int            w;

  task automatic drive_inputs();
    req0   = busy[0];
    we0    = r_we[0];
    addr0  = r_addr[0];
    wdata0 = r_wdata[0];
    req1   = busy[1];
    we1    = r_we[1];
    addr1  = r_addr[1];
    wdata1 = r_wdata[1];
  endtask

  initial begin
    reset     = 1'b1;
    mem_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      busy[i]    = 1'b0;
      r_we[i]    = 1'b0;
      r_addr[i]  = '0;
      r_wdata[i] = '0;
    end
    drive_inputs();
    #2;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    free_at    = 0;
    rr_last    = 1;
    t_gnt      = -10;
    t_rv       = -10;
    t_id       = 0;
    t_we       = 1'b0;
    t_addr     = '0;
    t_wdata    = '0;
    n_resets   = 0;
    force_both = 1'b1;

    for (int c = 0; c < NumCycles; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      // Requesters: finish after the grant cycle, optionally start a new command.
      for (int i = 0; i < 2; i++) begin
        if (busy[i] && t_gnt == c - 1 && t_id == i) busy[i] = 1'b0;
        if (!busy[i] && (force_both || $urandom_range(0, 1) == 1)) begin
          busy[i]    = 1'b1;
          r_we[i]    = 1'($urandom_range(0, 1));
          r_addr[i]  = {$urandom, $urandom};
          r_wdata[i] = {$urandom, $urandom};
        end
      end
      force_both = 1'b0;
      drive_inputs();
      mem_rdata = {$urandom, $urandom};

      if (c >= free_at && (busy[0] || busy[1])) begin
        if (busy[0] && busy[1]) begin
`ifdef DM_ARB_FIXED_PRIO_EN
          w = 0;
`else
          w = 1 - rr_last;
`endif
        end else begin
          w = busy[0] ? 0 : 1;
        end
        rr_last = w;
        t_id    = w;
        t_gnt   = c + 1;
        t_we    = r_we[w];
        t_addr  = r_addr[w];
        t_wdata = r_wdata[w];
        if (t_we) begin
          t_rv    = -10;
          free_at = c + 2;
        end else begin
          t_rv    = c + 1 + RdLat;
          free_at = c + 2 + RdLat;
        end
      end

      if (n_resets < 3 && c > t_gnt && c < t_rv && $urandom_range(0, 3) == 0) begin
        #2;
        reset = 1'b1;
        busy[0] = 1'b0;
        busy[1] = 1'b0;
        drive_inputs();
        #1;
        check_all_zero("mid_read_reset");
        t_gnt      = -10;
        t_rv       = -10;
        rr_last    = 1;
        free_at    = c + 1;
        force_both = 1'b1;
        n_resets++;
        @(negedge clk);
        reset = 1'b0;
      end else begin
        @(negedge clk);
        check_eq("gnt0", 64'(gnt0), 64'(t_gnt == c && t_id == 0));
        check_eq("gnt1", 64'(gnt1), 64'(t_gnt == c && t_id == 1));
        check_eq("mem_write", 64'(mem_write), 64'(t_gnt == c && t_we));
        check_eq("mem_read", 64'(mem_read), 64'(t_gnt == c && !t_we));
        check_eq("rvalid0", 64'(rvalid0), 64'(t_rv == c && t_id == 0));
        check_eq("rvalid1", 64'(rvalid1), 64'(t_rv == c && t_id == 1));
        if (t_gnt == c) begin
          check_eq("mem_addr", 64'(mem_addr), 64'(t_addr));
          check_eq("mem_wdata", 64'(mem_wdata), 64'(t_wdata));
        end
        if (t_rv == c) check_eq("rdata", 64'(rdata), 64'(mem_rdata));
      end
    end

    check_eq("resets_injected", 64'(n_resets > 0), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
